slider_debounce: RTL and testbench
==================================

SLIDER_DEBOUNCE -- requirements
Module: slider_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 10, the number of slider inputs.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), the consecutive cycles a changed level must persist; legal minimum 2.
REQ-003 SHALL have port clk  input  1  the single system clock; all flops use its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port sw_in  input  WIDTH  raw slider levels, asynchronous to clk.
REQ-006 SHALL have port sw_out  output  WIDTH  debounced levels, registered; drives the PIO input port.
REQ-007 SHALL have port sw_changed  output  1  one-cycle pulse, registered; high when any sw_out bit changed on that edge.
REQ-008 SHALL have port changed_mask  output  WIDTH  registered; the bits that changed on that edge, otherwise 0.
REQ-009 SHALL have port edge_clear  input  WIDTH  write-1-to-clear strobe for edge_capture.
REQ-010 SHALL have port edge_capture  output  WIDTH  sticky record of debounced changes.
REQ-011 SHALL have port irq  output  1  OR-reduction of edge_capture.

Function
REQ-012 SHALL pass each sw_in bit through a two-flop synchronizer before any other use.
REQ-013 SHALL run one independent two-state FSM per bit: STABLE (counter 0) and CANDIDATE.
- STABLE -> CANDIDATE, counter=1: on an edge where sync != sw_out.
- CANDIDATE, sync == sw_out: -> STABLE, counter=0, sw_out unchanged (bounce rejected).
- CANDIDATE, sync != sw_out, counter < DEBOUNCE_CYCLES-1: counter+1.
- CANDIDATE, sync != sw_out, counter == DEBOUNCE_CYCLES-1: sw_out bit takes the sync value on that edge; -> STABLE, counter=0.
REQ-014 SHALL therefore update sw_out exactly 2+DEBOUNCE_CYCLES edges after the first edge that samples a held sw_in change.
REQ-015 SHALL size the counter as $clog2(DEBOUNCE_CYCLES) bits; the counter never wraps.
REQ-016 SHALL assert sw_changed and load changed_mask on the same edge that sw_out updates; a simultaneous multi-bit change gives one pulse with all bits set in changed_mask.
REQ-017 SHALL keep sw_out constant while any bit's input keeps toggling faster than DEBOUNCE_CYCLES.

Reset
REQ-018 SHALL reset synchronizer flops, sw_out, counters, changed_mask, sw_changed and edge_capture to 0, and all FSMs to STABLE.
REQ-019 SHALL discard any pending candidate on reset; after release, a held-high input reappears on sw_out with full latency and with a sw_changed pulse.

Configuration
REQ-020 SHALL compile edge capture only when SLIDER_DEBOUNCE_EDGE_CAPTURE_EN is defined.
- Defined: edge_capture bits set from changed_mask and cleared by edge_clear bits. If set and clear hit the same bit on the same edge, set wins.
- Undefined: edge_capture and irq are tied to 0 and edge_clear is ignored; port list is unchanged.

Structure
REQ-021 SHALL place the FSM state typedef (STABLE, CANDIDATE) and the WIDTH and DEBOUNCE_CYCLES defaults in the shared package slider_debounce_pkg.
REQ-022 SHALL implement the per-bit synchronizer, FSM and counter as sub-module slider_debounce_bit, instantiated WIDTH times by a generate loop. The top level holds the change-pulse and edge-capture logic.

Verification (WIDTH=10, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-023 SHALL cover: reset, then sw_in=10'h001 held -> sw_out=10'h001 on the 6th edge; sw_changed high exactly one cycle; changed_mask=10'h001; irq=1.
REQ-024 SHALL cover: sw_in[3] alternating with 2-cycle high/low pulses for 40 cycles -> sw_out[3] stays 0 and sw_changed stays 0.
REQ-025 SHALL cover: sw_in bits 0 and 9 change on the same edge -> one sw_changed pulse with changed_mask=10'h201.
REQ-026 SHALL cover: reset_n pulsed low 4 edges after sw_in=10'h3FF -> sw_out=0 during reset; after release, sw_out=10'h3FF exactly 6 edges later.
REQ-027 SHALL cover: edge_capture=10'h004, edge_clear=10'h004 on the same edge as a new bit-2 debounced change -> bit stays 1; edge_clear alone -> edge_capture=0, irq=0.
REQ-028 SHALL cover: macro undefined, with the REQ-023 stimulus -> sw_out and sw_changed as in REQ-023; edge_capture=0 and irq=0 throughout.

Source files
------------

// File: rtl/slider_debounce_pkg.sv
// Shared FSM state type and parameter defaults for the slider debouncer.
// Purely declarative: no logic, no latency, no flow control.
package slider_debounce_pkg;

  localparam int WIDTH_DEFAULT           = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  typedef enum logic {
    STABLE    = 1'b0,
    CANDIDATE = 1'b1
  } db_state_t;

endpackage

// File: rtl/slider_debounce_bit.sv
// One slider bit: 2-flop synchronizer, then STABLE/CANDIDATE filter; level moves 2+DEBOUNCE_CYCLES edges after a held change.
// No backpressure; update is combinational and marks the edge on which level will change.
module slider_debounce_bit
  import slider_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_in,
  output logic level,
  output logic update
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          differ;
  db_state_t     state;
  logic [CW-1:0] cnt;

  assign differ = sync2 ^ level;
  assign update = (state == CANDIDATE) && differ && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      state <= STABLE;
      cnt   <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      unique case (state)
        STABLE: begin
          if (differ) begin
            state <= CANDIDATE;
            cnt   <= CW'(1);
          end
        end
        CANDIDATE: begin
          // Any sample matching the current level rejects the candidate as bounce.
          if (!differ) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            level <= sync2;
            state <= STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/slider_debounce.sv
// Debounced slider bank with registered change pulse/mask; optional sticky edge capture under SLIDER_DEBOUNCE_EDGE_CAPTURE_EN.
// Outputs move 2+DEBOUNCE_CYCLES edges after a held input change; no backpressure.
module slider_debounce
  import slider_debounce_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             sw_changed,
  output logic [WIDTH-1:0] changed_mask,
  input  logic [WIDTH-1:0] edge_clear,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq
);

  logic [WIDTH-1:0] update;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    slider_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .sw_in  (sw_in[i]),
      .level  (sw_out[i]),
      .update (update[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_changed   <= 1'b0;
      changed_mask <= '0;
    end else begin
      sw_changed   <= |update;
      changed_mask <= update;
    end
  end

`ifdef SLIDER_DEBOUNCE_EDGE_CAPTURE_EN
  // Set is applied after clear so a same-edge change is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~edge_clear) | update;
    end
  end

  assign irq = |edge_capture;
`else
  logic unused_edge_clear;

  assign unused_edge_clear = ^edge_clear;
  assign edge_capture      = '0;
  assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_slider_debounce.sv
// Randomized and directed bench for slider_debounce against a sample-history reference model.
module tb_slider_debounce;

  localparam int W = 10;
  localparam int D = 4;
`ifdef SLIDER_DEBOUNCE_EDGE_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] sw_in;
  logic [W-1:0] sw_out;
  logic         sw_changed;
  logic [W-1:0] changed_mask;
  logic [W-1:0] edge_clear;
  logic [W-1:0] edge_capture;
  logic         irq;

  int checks   = 0;
  int failures = 0;

  // Model state: raw samples waiting out the synchronizer delay, and the
  // last D values the filter has seen.
  logic [W-1:0] pipe[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] exp_out;
  logic [W-1:0] exp_mask;
  logic [W-1:0] exp_cap;
  logic         exp_chg;
  logic [31:0]  got;
  logic [31:0]  want;

  slider_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sw_in       (sw_in),
    .sw_out      (sw_out),
    .sw_changed  (sw_changed),
    .changed_mask(changed_mask),
    .edge_clear  (edge_clear),
    .edge_capture(edge_capture),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    pipe.delete();
    hist.delete();
    pipe.push_back('0);
    pipe.push_back('0);
    for (int i = 0; i < D; i++) hist.push_back('0);
    exp_out  = '0;
    exp_mask = '0;
    exp_cap  = '0;
    exp_chg  = 1'b0;
  endtask

  // A bit flips once the last D values seen all disagree with its output.
  task automatic step();
    logic [W-1:0] vis;
    logic [W-1:0] flip;
    bit           all_diff;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      vis = pipe.pop_front();
      pipe.push_back(sw_in);
      hist.push_back(vis);
      void'(hist.pop_front());
      flip = '0;
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        foreach (hist[k]) if (hist[k][b] == exp_out[b]) all_diff = 1'b0;
        flip[b] = all_diff;
      end
      exp_out  = exp_out ^ flip;
      exp_mask = flip;
      exp_chg  = |flip;
      exp_cap  = CAP_EN ? ((exp_cap & ~edge_clear) | flip) : '0;
    end
    @(negedge clk);
    got  = {sw_out, sw_changed, changed_mask, edge_capture, irq};
    want = {exp_out, exp_chg, exp_mask, exp_cap, |exp_cap};
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (sw_out !== '0) begin failures++; $display("FAIL reset_sw_out got=%h want=0", sw_out); end
    checks++;
    if (sw_changed !== 1'b0) begin failures++; $display("FAIL reset_sw_changed got=%b want=0", sw_changed); end
    checks++;
    if (changed_mask !== '0) begin failures++; $display("FAIL reset_mask got=%h want=0", changed_mask); end
    checks++;
    if ({edge_capture, irq} !== '0) begin failures++; $display("FAIL reset_capture got cap=%h irq=%b want 0", edge_capture, irq); end
  endtask

  task automatic test_single_bit();
    reset_n = 1'b1;
    sw_in   = 10'h001;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (got !== want) begin failures++; $display("FAIL single_model edge=%0d got=%h want=%h", e, got, want); end
      if (e == 5) begin
        checks++;
        if (sw_out !== 10'h000) begin failures++; $display("FAIL single_early edge=5 got=%h want=000", sw_out); end
      end
      if (e == 6) begin
        checks++;
        if ({sw_out, sw_changed, changed_mask} !== {10'h001, 1'b1, 10'h001}) begin
          failures++; $display("FAIL single_edge6 got out=%h chg=%b mask=%h want 001/1/001", sw_out, sw_changed, changed_mask);
        end
        checks++;
        if (irq !== CAP_EN) begin failures++; $display("FAIL single_irq got=%b want=%b", irq, CAP_EN); end
      end
      if (e == 7) begin
        checks++;
        if (sw_changed !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b want=0", sw_changed); end
      end
    end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 40; c++) begin
      sw_in[3] = ((c / 2) % 2) == 0;
      step();
      checks++;
      if (got !== want) begin failures++; $display("FAIL bounce_model cyc=%0d got=%h want=%h", c, got, want); end
      checks++;
      if (sw_out[3] !== 1'b0 || sw_changed !== 1'b0) begin
        failures++; $display("FAIL bounce_hold cyc=%0d got out3=%b chg=%b want 0/0", c, sw_out[3], sw_changed);
      end
    end
    sw_in[3] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (got !== want) begin failures++; $display("FAIL bounce_settle cyc=%0d got=%h want=%h", c, got, want); end
    end
  endtask

  task automatic test_simultaneous();
    int pulses = 0;
    sw_in = sw_in ^ 10'h201;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (got !== want) begin failures++; $display("FAIL simul_model cyc=%0d got=%h want=%h", c, got, want); end
      if (sw_changed) begin
        pulses++;
        checks++;
        if (changed_mask !== 10'h201) begin failures++; $display("FAIL simul_mask got=%h want=201", changed_mask); end
      end
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL simul_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_reset_midway();
    sw_in = 10'h3FF;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (got !== want) begin failures++; $display("FAIL midway_pre cyc=%0d got=%h want=%h", c, got, want); end
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (sw_out !== '0) begin failures++; $display("FAIL midway_async got=%h want=000", sw_out); end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (sw_out !== '0 || sw_changed !== 1'b0) begin failures++; $display("FAIL midway_held got out=%h chg=%b want 0", sw_out, sw_changed); end
    end
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (got !== want) begin failures++; $display("FAIL midway_model edge=%0d got=%h want=%h", e, got, want); end
      if (e == 5) begin
        checks++;
        if (sw_out !== '0) begin failures++; $display("FAIL midway_early got=%h want=000", sw_out); end
      end
      if (e == 6) begin
        checks++;
        if (sw_out !== 10'h3FF || sw_changed !== 1'b1) begin
          failures++; $display("FAIL midway_edge6 got out=%h chg=%b want 3ff/1", sw_out, sw_changed);
        end
      end
    end
  endtask

  task automatic test_edge_clear();
    edge_clear = 10'h3FF;
    step();
    edge_clear = '0;
    checks++;
    if (got !== want) begin failures++; $display("FAIL eclr_all got=%h want=%h", got, want); end
    sw_in[2] = 1'b0;
    for (int e = 1; e <= 6; e++) step();
    checks++;
    if (edge_capture !== (CAP_EN ? 10'h004 : 10'h000)) begin
      failures++; $display("FAIL eclr_capture got=%h want=%h", edge_capture, CAP_EN ? 10'h004 : 10'h000);
    end
    sw_in[2] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      if (e == 6) edge_clear = 10'h004;
      step();
      checks++;
      if (got !== want) begin failures++; $display("FAIL eclr_model edge=%0d got=%h want=%h", e, got, want); end
    end
    edge_clear = 10'h004;
    checks++;
    if (sw_out[2] !== 1'b1 || edge_capture !== (CAP_EN ? 10'h004 : 10'h000)) begin
      failures++; $display("FAIL eclr_set_wins got out2=%b cap=%h want 1/%h", sw_out[2], edge_capture, CAP_EN ? 10'h004 : 10'h000);
    end
    step();
    edge_clear = '0;
    checks++;
    if (edge_capture !== '0 || irq !== 1'b0) begin failures++; $display("FAIL eclr_clear got cap=%h irq=%b want 0/0", edge_capture, irq); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) sw_in[$urandom_range(0, W - 1)] ^= 1'b1;
      edge_clear = ($urandom_range(0, 5) == 0) ? W'($urandom) : '0;
      step();
      checks++;
      if (got !== want) begin failures++; $display("FAIL random_model cyc=%0d got=%h want=%h", c, got, want); end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    sw_in      = '0;
    edge_clear = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_bit();
    test_bounce();
    test_simultaneous();
    test_reset_midway();
    test_edge_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
